// File: rtl/usb_pkg.sv
// Shared USB definitions: PID codes, CRC residuals, transaction sequencer states
// and a couple of small helpers used by the decoder and the transaction controller.
package usb_pkg;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_SOF   = 4'b0101,
        PID_SETUP = 4'b1101,
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011,
        PID_DATA2 = 4'b0111,
        PID_MDATA = 4'b1111,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010,
        PID_STALL = 4'b1110,
        PID_NYET  = 4'b0110
    } pid_t;

    localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_DATA_WAIT   = 3'd1,
        ST_DATA_RX     = 3'd2,
        ST_HS_REQ      = 3'd3,
        ST_IN_REQ      = 3'd4,
        ST_IN_ACK_WAIT = 3'd5
    } txn_state_t;

    function automatic logic is_data_pid(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

    // Received byte count includes the two CRC16 bytes.
    function automatic logic [10:0] payload_len(input logic [10:0] cnt);
        return (cnt >= 11'd2) ? cnt - 11'd2 : 11'd0;
    endfunction

endpackage

// File: rtl/usb_toggle_bank.sv
// Per-endpoint DATA0/DATA1 toggle bits with clear-all, set, flip and a read port.
module usb_toggle_bank #(
    parameter int NUM_EP = 4
) (
    input  logic       clk48,
    input  logic       reset,
    input  logic       clear_all,
    input  logic       set_en,
    input  logic       flip_en,
    input  logic [3:0] wr_idx,
    input  logic [3:0] rd_idx,
    output logic       rd_val
);

    logic [NUM_EP-1:0] tog_q;
    logic [15:0]       tog_ext;

    // clear_all wins over set, set wins over flip
    always_ff @(posedge clk48 or posedge reset) begin
        if (reset) begin
            tog_q <= '0;
        end else if (clear_all) begin
            tog_q <= '0;
        end else begin
            for (int i = 0; i < NUM_EP; i++) begin
                if (wr_idx == 4'(i)) begin
                    if (set_en)       tog_q[i] <= 1'b1;
                    else if (flip_en) tog_q[i] <= ~tog_q[i];
                end
            end
        end
    end

    assign tog_ext = 16'(tog_q);
    assign rd_val  = tog_ext[rd_idx];

endmodule

// File: rtl/usb_transaction_ctrl.sv
// Device-side full-speed transaction sequencer: filters tokens, streams OUT/SETUP
// payload to endpoint buffers and chooses the handshake or IN data PID to transmit.
module usb_transaction_ctrl
    import usb_pkg::*;
#(
    parameter int NUM_EP         = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk48,
    input  logic              reset,
    input  logic [6:0]        dev_addr,
    input  logic              bus_reset,
    input  logic [3:0]        rx_pid,
    input  logic [6:0]        rx_addr,
    input  logic [3:0]        rx_endp,
    input  logic [10:0]       rx_frame,
    input  logic [7:0]        rx_byte,
    input  logic              rx_byte_valid,
    input  logic              rx_eop,
    input  logic              rx_good,
    input  logic [NUM_EP-1:0] ep_rx_ready,
    input  logic [NUM_EP-1:0] ep_tx_ready,
    input  logic [NUM_EP-1:0] ep_stall,
    output logic [3:0]        ep_sel,
    output logic [7:0]        ep_wr_data,
    output logic              ep_wr_en,
    output logic              ep_rx_commit,
    output logic              ep_rx_discard,
    output logic [10:0]       ep_rx_len,
    output logic              ep_rx_setup,
    output logic              ep_tx_done,
    output logic              tx_req,
    output logic [3:0]        tx_pid,
    input  logic              tx_ack,
    output logic              sof_pulse,
    output logic [10:0]       frame_num,
    output logic [2:0]        state_dbg
);

    localparam int              TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   T_LIM = TW'(TIMEOUT_CYCLES);
    localparam logic [4:0]      EP_LIM = 5'(NUM_EP);

    txn_state_t    state_q, state_n;
    logic [TW-1:0] timer_q, timer_n;
    logic [10:0]   cnt_q, cnt_n;
    logic          is_setup_q, is_setup_n;
    logic [3:0]    ep_sel_n, tx_pid_n, ep_idx;
    logic [7:0]    wr_data_n;
    logic [10:0]   len_n, frame_n;
    logic          wr_en_n, commit_n, discard_n, setup_n, done_n, sof_n;
    logic          tog_rd, tog_set, tog_flip, tog_clear;
    logic          idle_eval, pkt_ok, tok_match;
    logic [15:0]   stall16, rxrdy16, txrdy16;

    // A handshake acknowledged this cycle frees the FSM to take a new packet at once.
    assign idle_eval = (state_q == ST_IDLE) || (state_q == ST_HS_REQ && tx_ack);
    assign ep_idx    = idle_eval ? rx_endp : ep_sel;
    assign stall16   = 16'(ep_stall);
    assign rxrdy16   = 16'(ep_rx_ready);
    assign txrdy16   = 16'(ep_tx_ready);
    assign pkt_ok    = rx_eop & rx_good;
    assign tok_match = pkt_ok && (rx_addr == dev_addr) && ({1'b0, rx_endp} < EP_LIM);
    assign tx_req    = (state_q == ST_HS_REQ) || (state_q == ST_IN_REQ);
    assign state_dbg = state_q;

    usb_toggle_bank #(.NUM_EP(NUM_EP)) u_toggles (
        .clk48     (clk48),
        .reset     (reset),
        .clear_all (tog_clear),
        .set_en    (tog_set),
        .flip_en   (tog_flip),
        .wr_idx    (ep_sel),
        .rd_idx    (ep_idx),
        .rd_val    (tog_rd)
    );

    always_comb begin
        state_n    = state_q;
        ep_sel_n   = ep_sel;
        is_setup_n = is_setup_q;
        cnt_n      = cnt_q;
        tx_pid_n   = tx_pid;
        wr_data_n  = ep_wr_data;
        len_n      = ep_rx_len;
        setup_n    = ep_rx_setup;
        frame_n    = frame_num;
        wr_en_n    = 1'b0;
        commit_n   = 1'b0;
        discard_n  = 1'b0;
        done_n     = 1'b0;
        sof_n      = 1'b0;
        tog_set    = 1'b0;
        tog_flip   = 1'b0;
        tog_clear  = 1'b0;

        case (state_q)
            ST_DATA_WAIT: begin
                if (rx_byte_valid) begin
                    state_n   = ST_DATA_RX;
                    wr_en_n   = 1'b1;
                    wr_data_n = rx_byte;
                    cnt_n     = 11'd1;
                end else if (timer_q == T_LIM) begin
                    state_n = ST_IDLE;
                end
            end
            ST_DATA_RX: begin
                if (rx_byte_valid) begin
                    wr_en_n   = 1'b1;
                    wr_data_n = rx_byte;
                    if (cnt_q != 11'h7FF) cnt_n = cnt_q + 11'd1;
                end
                if (rx_eop) begin
                    state_n  = ST_HS_REQ;
                    tx_pid_n = PID_ACK;
                    if (!rx_good || !is_data_pid(rx_pid)) begin
                        discard_n = 1'b1;
                        state_n   = ST_IDLE;
                    end else if (is_setup_q) begin
                        commit_n = 1'b1;
                        setup_n  = 1'b1;
                        len_n    = payload_len(cnt_q);
                        tog_set  = 1'b1;
                    end else if (stall16[ep_idx]) begin
                        discard_n = 1'b1;
                        tx_pid_n  = PID_STALL;
                    end else if (!rxrdy16[ep_idx]) begin
                        discard_n = 1'b1;
                        tx_pid_n  = PID_NAK;
                    end else if ((rx_pid == PID_DATA1) != tog_rd) begin
                        discard_n = 1'b1;  // host retry of a packet already accepted
                    end else begin
                        commit_n = 1'b1;
                        setup_n  = 1'b0;
                        len_n    = payload_len(cnt_q);
                        tog_flip = 1'b1;
                    end
                end
            end
            ST_HS_REQ:   if (tx_ack) state_n = ST_IDLE;
            ST_IN_REQ:   if (tx_ack) state_n = ST_IN_ACK_WAIT;
            ST_IN_ACK_WAIT: begin
                if (pkt_ok) begin
                    state_n = ST_IDLE;
                    if (rx_pid == PID_ACK) begin
                        done_n   = 1'b1;
                        tog_flip = 1'b1;
                    end
                end else if (timer_q == T_LIM) begin
                    state_n = ST_IDLE;
                end
            end
            default: ;
        endcase

        if (idle_eval && pkt_ok) begin
            if (rx_pid == PID_SOF) begin
                sof_n   = 1'b1;
                frame_n = rx_frame;
            end else if (tok_match && (rx_pid == PID_OUT || rx_pid == PID_SETUP)) begin
                state_n    = ST_DATA_WAIT;
                ep_sel_n   = rx_endp;
                is_setup_n = (rx_pid == PID_SETUP);
                cnt_n      = 11'd0;
            end else if (tok_match && rx_pid == PID_IN) begin
                ep_sel_n = rx_endp;
                if (stall16[ep_idx]) begin
                    state_n  = ST_HS_REQ;
                    tx_pid_n = PID_STALL;
                end else if (!txrdy16[ep_idx]) begin
                    state_n  = ST_HS_REQ;
                    tx_pid_n = PID_NAK;
                end else begin
                    state_n  = ST_IN_REQ;
                    tx_pid_n = tog_rd ? PID_DATA1 : PID_DATA0;
                end
            end
        end

        if (bus_reset) begin
            state_n   = ST_IDLE;
            tog_clear = 1'b1;
            tog_set   = 1'b0;
            tog_flip  = 1'b0;
            wr_en_n   = 1'b0;
            commit_n  = 1'b0;
            done_n    = 1'b0;
            sof_n     = 1'b0;
            discard_n = (state_q == ST_DATA_RX);
        end

        if (state_n != state_q)
            timer_n = '0;
        else if (state_q == ST_DATA_WAIT || state_q == ST_IN_ACK_WAIT)
            timer_n = timer_q + TW'(1);
        else
            timer_n = timer_q;
    end

    always_ff @(posedge clk48 or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            cnt_q         <= '0;
            is_setup_q    <= 1'b0;
            ep_sel        <= '0;
            ep_wr_data    <= '0;
            ep_wr_en      <= 1'b0;
            ep_rx_commit  <= 1'b0;
            ep_rx_discard <= 1'b0;
            ep_rx_len     <= '0;
            ep_rx_setup   <= 1'b0;
            ep_tx_done    <= 1'b0;
            tx_pid        <= '0;
            sof_pulse     <= 1'b0;
            frame_num     <= '0;
        end else begin
            state_q       <= state_n;
            timer_q       <= timer_n;
            cnt_q         <= cnt_n;
            is_setup_q    <= is_setup_n;
            ep_sel        <= ep_sel_n;
            ep_wr_data    <= wr_data_n;
            ep_wr_en      <= wr_en_n;
            ep_rx_commit  <= commit_n;
            ep_rx_discard <= discard_n;
            ep_rx_len     <= len_n;
            ep_rx_setup   <= setup_n;
            ep_tx_done    <= done_n;
            tx_pid        <= tx_pid_n;
            sof_pulse     <= sof_n;
            frame_num     <= frame_n;
        end
    end

endmodule

// File: doc/usb_transaction_ctrl.md
Name: usb_transaction_ctrl

Overview:
- Device-side USB full-speed transaction sequencer. Sits directly after the packet decoder.
- Consumes decoded tokens, data bytes and packet-complete strobes. Filters traffic by device address and endpoint.
- Maintains per-endpoint data toggles. Streams OUT/SETUP payload bytes to endpoint buffers.
- Decides ACK/NAK/STALL and requests handshake or IN-data transmission from the packet encoder, with turnaround timeouts.

Parameters:
NUM_EP, 4, number of endpoints implemented (1..16); endpoints >= NUM_EP are ignored.
TIMEOUT_CYCLES, 64, clk48 cycles to wait for host data/handshake after a token or IN data (~16 bit times).

Ports:
clk48  input  1  48 MHz clock
reset  input  1  asynchronous, active-high reset
dev_addr  input  7  assigned device address
bus_reset  input  1  USB bus reset from decoder
rx_pid  input  4  decoded PID
rx_addr  input  7  token address
rx_endp  input  4  token endpoint
rx_frame  input  11  SOF frame number
rx_byte  input  8  payload byte
rx_byte_valid  input  1  payload byte strobe
rx_eop  input  1  packet complete strobe (1 cycle)
rx_good  input  1  PID and CRC valid, qualifies rx_eop
ep_rx_ready  input  NUM_EP  endpoint can accept an OUT/SETUP packet
ep_tx_ready  input  NUM_EP  endpoint has IN data queued
ep_stall  input  NUM_EP  endpoint halted
ep_sel  output  4  endpoint of current transaction
ep_wr_data  output  8  payload byte to endpoint buffer
ep_wr_en  output  1  payload byte write strobe
ep_rx_commit  output  1  1-cycle: accept packet, length on ep_rx_len
ep_rx_discard  output  1  1-cycle: drop buffered bytes
ep_rx_len  output  11  payload bytes excluding CRC16
ep_rx_setup  output  1  committed packet was SETUP
ep_tx_done  output  1  1-cycle: IN data acknowledged by host
tx_req  output  1  request encoder transmission
tx_pid  output  4  PID to send (ACK/NAK/STALL/DATA0/DATA1)
tx_ack  input  1  encoder accepted request
sof_pulse  output  1  1-cycle on good SOF
frame_num  output  11  last good SOF frame

Behaviour:
- Reset: all outputs 0; state IDLE; all toggles 0; frame_num 0.
- Token match = rx_eop & rx_good & rx_addr==dev_addr & rx_endp<NUM_EP, evaluated in the rx_eop cycle. ep_sel is latched on match.
- States: IDLE, DATA_WAIT, DATA_RX, HS_REQ, IN_REQ, IN_ACK_WAIT.
- IDLE:
  - Good SOF (any address): sof_pulse=1, frame_num<=rx_frame.
  - Matched OUT/SETUP token -> DATA_WAIT; is_setup latched.
  - Matched IN token:
    - ep_stall -> HS_REQ with STALL.
    - Else !ep_tx_ready -> HS_REQ with NAK.
    - Else -> IN_REQ with tx_pid = toggle ? DATA1 : DATA0.
  - Unmatched or bad packets are ignored.
- DATA_WAIT:
  - Any rx_byte_valid -> DATA_RX, forwarding that byte.
  - Timer reaching TIMEOUT_CYCLES -> IDLE, no outputs.
- DATA_RX:
  - ep_wr_en mirrors rx_byte_valid with 1-cycle latency. Byte counter saturates at 2047.
  - On rx_eop:
    - !rx_good or PID not DATA0/DATA1 -> discard, IDLE, no handshake.
    - SETUP -> ep0-style: commit, ep_rx_setup=1, toggle<=1, ACK. Ignores ep_stall and ep_rx_ready.
    - ep_stall -> discard, STALL.
    - !ep_rx_ready -> discard, NAK.
    - Data PID toggle != expected toggle -> discard, ACK (duplicate retry).
    - Otherwise commit, ep_rx_len = count-2 (floor 0), toggle flips, ACK.
  - Commit/discard are asserted in the cycle after rx_eop.
- HS_REQ: tx_req=1 with tx_pid held until the tx_ack cycle, then IDLE.
- IN_REQ: tx_req held until tx_ack, then IN_ACK_WAIT with timer cleared.
- IN_ACK_WAIT:
  - Good ACK -> ep_tx_done, toggle flips, IDLE.
  - Any other good packet, or timeout -> IDLE, toggle unchanged.
- Timer: clears on each state entry. Counts only in DATA_WAIT and IN_ACK_WAIT.
- bus_reset, any state, any cycle:
  - Next cycle: IDLE, all toggles 0, tx_req 0.
  - If mid-DATA_RX, ep_rx_discard pulses once.
- rx_eop and tx_ack in the same cycle: tx_ack is handled first; the packet is ignored unless the state is IDLE after the transition.
- Widths: byte counter 11 bits; toggles NUM_EP bits, 1 per endpoint.

Decomposition:
- Shared package usb_pkg: Pid enum, CRC residual constants, TxnState enum.
- Both the packet decoder and this block import the Pid enum from usb_pkg.
- One sub-module, usb_toggle_bank: per-endpoint toggle register with flip, set, clear-all and read ports.

Test Plan:
- dev_addr=5; OUT ep1 addr5, DATA0 with 4 bytes+CRC, ep_rx_ready=1 -> 6 ep_wr_en; commit with ep_rx_len=4; tx_pid ACK; toggle[1]=1.
- Repeat the same DATA0 -> discard, ACK, toggle[1] stays 1. Then send it with ep_rx_ready=0 -> discard, NAK.
- SETUP ep0, DATA0 8 bytes -> commit, ep_rx_setup=1, len 8, ACK, toggle[0]=1, even with ep_stall[0]=1.
- IN ep2 with ep_tx_ready[2]=1 -> tx_pid DATA0. Host ACK -> ep_tx_done, toggle[2]=1. Second IN with no ACK for 64 cycles -> IDLE, no ep_tx_done, toggle[2]=1.
- Tokens to addr 6 and to endp 7 (NUM_EP=4) -> no outputs. Good SOF frame 0x3A5 -> sof_pulse, frame_num=0x3A5. Bad-CRC DATA after OUT -> discard, no tx_req.
- bus_reset mid-DATA_RX -> one ep_rx_discard, IDLE, all toggles 0. Async reset mid-IN_REQ -> tx_req 0 immediately.
